// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter that hands the shared Tx/SS FIFO write
// port to one requester at a time and holds it for a whole burst, so frames
// from different requesters never interleave. A burst ends on the requester's
// last beat, on the beat-count cap, or when the requester stalls too long.
module spi_xfer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int SS_W      = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*SS_W-1:0]  req_ss,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic                     fifo_full,
  output logic                     wr_en,
  output logic [31:0]              tx_data_out,
  output logic [31:0]              ss_data_out,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        grantId_q, grantId_d;
  logic [2:0]        lastGrant_q, lastGrant_d;
  logic [8:0]        beatCnt_q, beatCnt_d;
  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
  logic              timeoutErr_q, timeoutErr_d;

  logic              selValid;
  logic              selLast;
  logic [DATA_W-1:0] selData;
  logic [SS_W-1:0]   selSs;
  logic [7:0]        validPad;
  logic [7:0]        readyPad;
  logic [3:0]        cand;
  logic              pickValid;
  logic [2:0]        pickId;
  logic              portOpen;
  logic              beat;

  // Route the granted requester's valid/last/data/slave-select to the write path.
  always_comb begin
    selValid = 1'b0;
    selLast  = 1'b0;
    selData  = '0;
    selSs    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantId_q == 3'(i)) begin
        selValid = req_valid[i];
        selLast  = req_last[i];
        selData  = req_data[i*DATA_W +: DATA_W];
        selSs    = req_ss[i*SS_W +: SS_W];
      end
    end
  end

  // Pick the first valid requester after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    validPad = '0;
    validPad[NUM_REQ-1:0] = req_valid;
    pickValid = 1'b0;
    pickId    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, lastGrant_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!pickValid && validPad[cand[2:0]]) begin
        pickValid = 1'b1;
        pickId    = cand[2:0];
      end
    end
  end

  // Same-cycle handshake so a full FIFO blocks the write in the very cycle it is seen.
  always_comb begin
    portOpen    = (state_q == S_BURST) && ARESETN && !fifo_full;
    beat        = portOpen && selValid;
    readyPad    = '0;
    if (portOpen) readyPad[grantId_q] = 1'b1;
    req_ready   = readyPad[NUM_REQ-1:0];
    wr_en       = beat;
    tx_data_out = '0;
    ss_data_out = '0;
    if (beat) begin
      tx_data_out[DATA_W-1:0] = selData;
      ss_data_out[SS_W-1:0]   = selSs;
    end
  end

  // Grant, burst accounting and release decisions.
  always_comb begin
    state_d      = state_q;
    grantId_d    = grantId_q;
    lastGrant_d  = lastGrant_q;
    beatCnt_d    = beatCnt_q;
    idleCnt_d    = idleCnt_q;
    timeoutErr_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (enable && pickValid) begin
        state_d   = S_BURST;
        grantId_d = pickId;
        beatCnt_d = '0;
        idleCnt_d = '0;
      end
    end else begin
      if (beat) begin
        beatCnt_d = beatCnt_q + 9'd1;
        idleCnt_d = '0;
        if (selLast || (beatCnt_q + 9'd1 == 9'(MAX_BURST))) begin
          state_d     = S_IDLE;
          lastGrant_d = grantId_q;
        end
      end else if (fifo_full && selValid) begin
        idleCnt_d = idleCnt_q;
      end else if (idleCnt_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d      = S_IDLE;
        lastGrant_d  = grantId_q;
        timeoutErr_d = 1'b1;
      end else begin
        idleCnt_d = idleCnt_q + IDLE_W'(1);
      end
    end
  end

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      grantId_q    <= '0;
      lastGrant_q  <= 3'(NUM_REQ - 1);
      beatCnt_q    <= '0;
      idleCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grantId_q    <= grantId_d;
      lastGrant_q  <= lastGrant_d;
      beatCnt_q    <= beatCnt_d;
      idleCnt_q    <= idleCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign grant_id    = grantId_q;
  assign busy        = (state_q == S_BURST);
  assign timeout_err = timeoutErr_q;

endmodule
